// File: rtl/bitserial_mac_engine.sv
// Bit-serial multi-lane MAC: weight bits are consumed LSB first, one per cycle, and each lane accumulates into a saturating register.
// Latency is P RUN cycles plus one DONE cycle; the result is held in DONE until out_ready, and in_ready is high only in IDLE.
module bitserial_mac_engine #(
  parameter int AW    = 8,
  parameter int WW    = 8,
  parameter int ACCW  = 20,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*AW-1:0]      act,
  input  logic [LANES*WW-1:0]      wgt,
  input  logic [$clog2(WW+1)-1:0]  prec,
  input  logic                     signed_mode,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACCW-1:0]    acc_out,
  output logic [LANES-1:0]         ovf
);

  localparam int PW  = $clog2(WW+1);
  localparam int PRW = AW + WW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [LANES*AW-1:0] act_r;
  logic [LANES*WW-1:0] wgt_r;
  logic [PW-1:0]       p_r, p_eff, k;
  logic                sm_r;
  logic                accept, last;

  assign p_eff  = (prec == '0 || prec > PW'(WW)) ? PW'(WW) : prec;
  assign accept = in_valid && (state == IDLE);
  assign last   = (k == p_r - 1'b1);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      act_r <= '0;
      wgt_r <= '0;
      p_r   <= '0;
      sm_r  <= 1'b0;
      k     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        act_r <= act;
        wgt_r <= wgt;
        p_r   <= p_eff;
        sm_r  <= signed_mode;
        k     <= '0;
      end else if (state == RUN) begin
        k <= last ? '0 : k + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [AW-1:0]   a;
    logic [WW-1:0]   w;
    logic            wbit, sat;
    logic [PRW-1:0]  a_ext, term, prod, prod_nx;
    logic [ACCW:0]   prod_acc, sum;
    logic [ACCW-1:0] acc, acc_sat;
    logic            ovf_q;

    assign a        = act_r[i*AW +: AW];
    assign w        = wgt_r[i*WW +: WW];
    assign wbit     = |(w & (WW'(1) << k));
    assign a_ext    = {{WW{sm_r & a[AW-1]}}, a};
    assign term     = wbit ? (a_ext << k) : '0;
    // Top weight bit of a two's-complement weight carries negative weight.
    assign prod_nx  = (sm_r && last) ? prod - term : prod + term;
    assign prod_acc = {{(ACCW+1-PRW){sm_r & prod_nx[PRW-1]}}, prod_nx};
    assign sum      = {acc[ACCW-1], acc} + prod_acc;
    assign sat      = sum[ACCW] ^ sum[ACCW-1];
    assign acc_sat  = sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        prod  <= '0;
        acc   <= '0;
        ovf_q <= 1'b0;
      end else if (state == IDLE) begin
        if (acc_clr) begin
          acc   <= '0;
          ovf_q <= 1'b0;
        end
        if (in_valid) prod <= '0;
      end else if (state == RUN) begin
        prod <= prod_nx;
        if (last) begin
          acc <= sat ? acc_sat : sum[ACCW-1:0];
          if (sat) ovf_q <= 1'b1;
        end
      end
    end

    assign acc_out[i*ACCW +: ACCW] = acc;
    assign ovf[i]                  = ovf_q;
  end

endmodule

// File: tb/tb_bitserial_mac_engine.sv
// Randomized and directed bench for bitserial_mac_engine against an arithmetic reference model.
module tb_bitserial_mac_engine;
  localparam int AW = 8, WW = 8, ACCW = 20, LANES = 4;
  localparam longint MAXV = (64'sd1 <<< (ACCW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACCW-1));

  logic                  clk = 0, rstn = 0;
  logic                  in_valid = 0, in_ready;
  logic [LANES*AW-1:0]   act = '0;
  logic [LANES*WW-1:0]   wgt = '0;
  logic [3:0]            prec = 4'd8;
  logic                  signed_mode = 0, acc_clr = 0;
  logic                  out_valid, out_ready = 0;
  logic [LANES*ACCW-1:0] acc_out;
  logic [LANES-1:0]      ovf;

  int     total_cnt = 0, pass_cnt = 0;
  longint acc_m [LANES];
  bit     ovf_m [LANES];

  bitserial_mac_engine #(.AW(AW), .WW(WW), .ACCW(ACCW), .LANES(LANES)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .prec(prec), .signed_mode(signed_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf));

  always #5 clk = ~clk;

  function automatic int eff_p(input int p);
    return (p == 0 || p > WW) ? WW : p;
  endfunction

  function automatic longint prod_m(input logic [AW-1:0] a, input logic [WW-1:0] w,
                                    input int p, input bit sm);
    longint av, wv;
    int pe;
    pe = eff_p(p);
    av = sm ? longint'($signed(a)) : longint'(a);
    wv = longint'(w) & ((64'sd1 <<< pe) - 1);
    if (sm && wv >= (64'sd1 <<< (pe-1))) wv = wv - (64'sd1 <<< pe);
    return av * wv;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LANES; i++) begin
      acc_m[i] = 0;
      ovf_m[i] = 0;
    end
  endfunction

  function automatic void model_op(input logic [LANES*AW-1:0] a, input logic [LANES*WW-1:0] w,
                                   input int p, input bit sm, input bit clr);
    longint s;
    if (clr) model_clear();
    for (int i = 0; i < LANES; i++) begin
      s = acc_m[i] + prod_m(a[i*AW +: AW], w[i*WW +: WW], p, sm);
      if (s > MAXV) begin s = MAXV; ovf_m[i] = 1; end
      else if (s < MINV) begin s = MINV; ovf_m[i] = 1; end
      acc_m[i] = s;
    end
  endfunction

  function automatic logic [LANES*ACCW-1:0] exp_acc();
    logic [LANES*ACCW-1:0] ev;
    for (int i = 0; i < LANES; i++) ev[i*ACCW +: ACCW] = ACCW'(acc_m[i]);
    return ev;
  endfunction

  function automatic logic [LANES-1:0] exp_ovf();
    logic [LANES-1:0] ev;
    for (int i = 0; i < LANES; i++) ev[i] = ovf_m[i];
    return ev;
  endfunction

  // One full operation: accept, count latency, compare, optional backpressure, handshake.
  task automatic do_op(input logic [LANES*AW-1:0] a, input logic [LANES*WW-1:0] w,
                       input logic [3:0] p, input bit sm, input bit clr, input int hold);
    int cyc;
    bit got;
    logic [LANES*ACCW-1:0] snap;
    @(negedge clk);
    act = a; wgt = w; prec = p; signed_mode = sm; acc_clr = clr; in_valid = 1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL op_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    model_op(a, w, int'(p), sm, clr);
    cyc = 0; got = 0;
    while (cyc < 40 && !got) begin
      in_valid = 1'($urandom); acc_clr = 1'($urandom);
      act = $urandom; wgt = $urandom; prec = 4'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
      got = out_valid;
    end
    in_valid = 0; acc_clr = 0;
    total_cnt++;
    if (!got || cyc != eff_p(int'(p))) $display("FAIL op_latency: got %0d cycles want %0d", cyc, eff_p(int'(p)));
    else pass_cnt++;
    if (!got) return;
    total_cnt++;
    if (acc_out !== exp_acc()) $display("FAIL op_acc: got %h want %h", acc_out, exp_acc());
    else pass_cnt++;
    total_cnt++;
    if (ovf !== exp_ovf()) $display("FAIL op_ovf: got %b want %b", ovf, exp_ovf());
    else pass_cnt++;
    snap = acc_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); acc_clr = 1'($urandom); act = $urandom;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== snap)
        $display("FAIL hold_stable: out_valid=%b in_ready=%b acc=%h want 1 0 %h", out_valid, in_ready, acc_out, snap);
      else pass_cnt++;
    end
    in_valid = 0; acc_clr = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic check_idle_zero(input string name);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== '0 || ovf !== '0)
      $display("FAIL %s: in_ready=%b out_valid=%b acc=%h ovf=%b want 1 0 0 0", name, in_ready, out_valid, acc_out, ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rstn = 0;
    #3;
    check_idle_zero("reset_held");
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    check_idle_zero("reset_release");
    model_clear();
  endtask

  task automatic test_directed();
    do_op(32'h0000_0067, 32'h0000_000A, 4'd8, 1, 0, 0);
    total_cnt++;
    if (acc_out[ACCW-1:0] !== 20'h00406) $display("FAIL dir_1030: got %h want 00406", acc_out[ACCW-1:0]);
    else pass_cnt++;
    do_op(32'h0000_003F, 32'h0000_00E1, 4'd8, 1, 0, 0);
    total_cnt++;
    if (acc_out[ACCW-1:0] !== 20'hFFC65) $display("FAIL dir_m923: got %h want FFC65", acc_out[ACCW-1:0]);
    else pass_cnt++;
    do_op(32'h0000_00B4, 32'h0000_00FC, 4'd4, 1, 1, 0);
    total_cnt++;
    if (acc_out[ACCW-1:0] !== 20'd304) $display("FAIL dir_304: got %0d want 304", acc_out[ACCW-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_prec_edges();
    do_op(32'h8155_7FC3, 32'hF00F_A5B6, 4'd0, 1, 1, 0);
    do_op(32'hFF01_807F, 32'h0180_FF7F, 4'd1, 1, 0, 0);
    do_op(32'hFF01_807F, 32'h0180_FF7F, 4'd15, 0, 0, 0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 1, 0, 0);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 32; n++) begin
      do_op(32'h0000_0080, 32'h0000_0080, 4'd8, 1, (n == 0), 0);
      if (n == 30) begin
        total_cnt++;
        if (ovf !== 4'b0000) $display("FAIL sat_pre_ovf: got %b want 0000", ovf);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (acc_out !== {60'd0, 20'h7FFFF} || ovf !== 4'b0001)
      $display("FAIL sat_final: acc=%h ovf=%b want 7ffff lane0, ovf 0001", acc_out, ovf);
    else pass_cnt++;
    // Clear without an operation.
    @(negedge clk); acc_clr = 1; in_valid = 0;
    @(posedge clk); #1; acc_clr = 0;
    model_clear();
    check_idle_zero("clr_idle");
    do_op(32'h0000_0080, 32'h0000_0080, 4'd8, 0, 0, 0);
    total_cnt++;
    if (acc_out[ACCW-1:0] !== 20'd16384) $display("FAIL unsigned_16384: got %0d want 16384", acc_out[ACCW-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_op($urandom, $urandom, 4'd8, 1, 0, 5);
    do_op($urandom, $urandom, 4'd3, 0, 0, 5);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    act = 32'h7F7F_7F7F; wgt = 32'h7F7F_7F7F; prec = 4'd8; signed_mode = 1; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rstn = 0;
    #1;
    check_idle_zero("reset_mid_run");
    model_clear();
    @(negedge clk); rstn = 1;
    do_op(32'hC0DE_1234, 32'h5A5A_A5A5, 4'd8, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      do_op($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_prec_edges();
    test_saturation();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end
endmodule

// File: doc/bitserial_mac_engine.md
BITSERIAL_MAC_ENGINE -- requirements
Module: bitserial_mac_engine

Interface
REQ-001 Parameter AW, default 8: activation width per lane in bits.
REQ-002 Parameter WW, default 8: maximum weight precision in bits.
REQ-003 Parameter ACCW, default 20: accumulator width per lane; ACCW SHALL be at least AW+WW+1.
REQ-004 Parameter LANES, default 4: number of parallel MAC lanes sharing one control path.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  operand set offered.
REQ-008 in_ready  out  1  engine accepts operands (IDLE only).
REQ-009 act  in  LANES*AW  activations; lane i at bits [i*AW +: AW].
REQ-010 wgt  in  LANES*WW  weights; lane i at bits [i*WW +: WW].
REQ-011 prec  in  $clog2(WW+1)  weight bits used, legal 1..WW; 0 or >WW treated as WW.
REQ-012 signed_mode  in  1  1 = act and weight two's complement; 0 = both unsigned.
REQ-013 acc_clr  in  1  clear accumulators and overflow flags; sampled in IDLE only.
REQ-014 out_valid  out  1  accumulator update complete.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 acc_out  out  LANES*ACCW  signed accumulator per lane.
REQ-017 ovf  out  LANES  sticky saturation flag per lane.

Function
REQ-018 FSM states: IDLE, RUN, DONE; in_ready SHALL be 1 exactly in IDLE.
REQ-019 IDLE->RUN on in_valid&in_ready; act, wgt, effective prec (P), signed_mode latched; bit counter k=0; product registers cleared.
REQ-020 In RUN, each cycle processes weight bit k (LSB first) for all lanes: term = (act AND wgt[k]) << k, extended to AW+WW bits (sign-extended when signed_mode=1).
REQ-021 When signed_mode=1 and k=P-1, the term SHALL be subtracted (two's-complement weight sign bit); otherwise added.
REQ-022 Weight bits at or above P SHALL be ignored.
REQ-023 RUN lasts exactly P cycles; on the last RUN edge each lane adds its sign-extended (AW+WW)-bit product to its accumulator; FSM -> DONE.
REQ-024 Accumulator add SHALL saturate to [-2^(ACCW-1), 2^(ACCW-1)-1]; on saturation that lane's ovf SHALL set and stay set until acc_clr or reset.
REQ-025 out_valid SHALL be 1 exactly in DONE; acc_out SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 DONE->IDLE on out_ready=1; earliest next acceptance one cycle later.
REQ-027 Latency: acceptance at edge T -> out_valid first high in cycle after edge T+P (P+1 cycles total, P RUN plus handshake).
REQ-028 acc_clr in IDLE without acceptance: accumulators and ovf cleared at the next edge.
REQ-029 acc_clr together with acceptance: accumulators and ovf cleared; the new product then accumulates onto zero.
REQ-030 acc_clr, in_valid, and operand changes outside IDLE SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-031 Lanes SHALL be arithmetically independent; saturation in one lane SHALL NOT affect others.

Reset
REQ-032 rstn=0 SHALL immediately force: state IDLE, k=0, acc_out=0, ovf=0, out_valid=0, product registers 0; in_ready=1 while in IDLE.
REQ-033 Reset asserted mid-RUN or in DONE SHALL abort the operation with no accumulator update; after release the engine SHALL accept at the first valid edge.

Verification
REQ-034 Signed, P=8, lane0 act=0x67, wgt=0x0A -> acc_out lane0=1030 (0x00406); out_valid in the 9th cycle after acceptance.
REQ-035 Follow-up, no clear, act=0x3F, wgt=0xE1 (-31) -> product -1953; acc lane0=-923 (0xFFC65).
REQ-036 Signed, P=4, act=0xB4 (-76), wgt=0xFC (low nibble -4) after acc_clr -> acc=304; out_valid 5 cycles after acceptance; upper wgt bits ignored.
REQ-037 act=0x80, wgt=0x80, P=8: signed -> +16384 per op; unsigned -> 16384; 32 signed ops from zero -> acc=0x7FFFF, ovf=1 on 32nd; other lanes (act=0) stay 0, ovf=0.
REQ-038 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, acc_out held, in_ready=0; acc_clr and in_valid pulses ignored.
REQ-039 rstn pulsed low at RUN k=3 -> all outputs 0 immediately; new op after release produces a fresh correct result.
